// File: rtl/joy_serial_reader.sv
// Reads a daisy-chained 74HC165-style joystick chain and publishes one word per channel every frame.
// Define JOY_DEBOUNCE_EN to publish a frame only when it repeats the previously completed frame.
`timescale 1ns/1ps
module joy_serial_reader #(
   parameter int NUM_CH      = 2,
   parameter int BITS        = 12,
   parameter int DIV         = 8,
   parameter int ACTIVE_HIGH = 0
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   output logic                   joy_clk,
   output logic                   joy_load,
   input  logic                   joy_data,
   output logic [NUM_CH*BITS-1:0] joy_out,
   output logic                   frame_stb
);
   localparam int TOTAL = NUM_CH * BITS;
   localparam int DW    = $clog2(DIV);
   localparam int SW    = $clog2(TOTAL + 1);
   localparam logic [TOTAL-1:0] RELEASED  = (ACTIVE_HIGH != 0) ? {TOTAL{1'b0}} : {TOTAL{1'b1}};
   localparam logic [DW-1:0]    DCNT_LAST = DW'(DIV - 1);
   localparam logic [SW-1:0]    SLOT_LAST = SW'(TOTAL);
   localparam logic [SW-1:0]    SLOT_ZERO = {SW{1'b0}};

   logic [DW-1:0]    dcnt;
   logic             phase;
   logic             sync_a;
   logic             sd;
   logic [SW-1:0]    slot;
   logic [TOTAL-1:0] sreg;
   logic [TOTAL-1:0] sreg_next;
   logic [TOTAL-1:0] frame_val;
   logic             div_end;
   logic             rise;
   logic             fall;
   logic             last_sample;
   logic             take;
`ifdef JOY_DEBOUNCE_EN
   logic [TOTAL-1:0] prev;
`endif

   // Phase edges, next shift-register value and the capture decision
   always_comb begin
      div_end = (dcnt == DCNT_LAST);
      rise    = div_end & ~phase;
      fall    = div_end & phase;
      if (rise && (slot != SLOT_ZERO)) begin
         sreg_next = (sreg << 1) | TOTAL'(sd);
      end else begin
         sreg_next = sreg;
      end
      last_sample = rise & (slot == SLOT_LAST);
      frame_val   = (ACTIVE_HIGH != 0) ? ~sreg_next : sreg_next;
`ifdef JOY_DEBOUNCE_EN
      take = last_sample & (sreg_next == prev);
`else
      take = last_sample;
`endif
   end

   // Divider, slot sequencing, synchroniser and the published word (captured on the final sample edge)
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dcnt      <= {DW{1'b0}};
         phase     <= 1'b0;
         slot      <= SLOT_ZERO;
         joy_load  <= 1'b1;
         sync_a    <= 1'b1;
         sd        <= 1'b1;
         sreg      <= {TOTAL{1'b1}};
         joy_out   <= RELEASED;
         frame_stb <= 1'b0;
      end else begin
         dcnt  <= div_end ? {DW{1'b0}} : dcnt + DW'(1);
         phase <= phase ^ div_end;
         if (fall) begin
            slot <= (slot == SLOT_LAST) ? SLOT_ZERO : slot + SW'(1);
         end
         joy_load  <= (slot != SLOT_ZERO);
         sync_a    <= joy_data;
         sd        <= sync_a;
         sreg      <= sreg_next;
         frame_stb <= take;
         if (take) begin
            joy_out <= frame_val;
         end
      end
   end

`ifdef JOY_DEBOUNCE_EN
   // Shadow of the last completed frame, refreshed every frame
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         prev <= {TOTAL{1'b1}};
      end else if (last_sample) begin
         prev <= sreg_next;
      end
   end
`endif

   assign joy_clk = phase;
endmodule
